gpio_scan_deserializer: RTL and testbench

Bit-serial front end that sits directly upstream of `openram_testchip` on the GPIO path. It shifts a request packet in over a single GPIO pin and presents it, fully assembled, on the parallel `gpio_packet` input of the control logic. It also captures the control logic's `sram_data` result and shifts it back out on a second pin, full-duplex with the next packet. This lets the SRAM macros be exercised with a handful of pads instead of a wide parallel bus.

---
 rtl/gpio_scan_deserializer.sv | 108 ++++++++++
 tb/tb_gpio_scan_deserializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_scan_deserializer.sv
// ============================================================================
// Module  : gpio_scan_deserializer
// Brief   : Bit-serial GPIO front end. Assembles request packets from a scan
//           pin and shifts captured SRAM read data back out, full-duplex.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_scan_deserializer #(
  parameter int PACKET_WIDTH = 86,
  parameter int DATA_WIDTH   = 64,
  parameter int CNT_WIDTH    = $clog2(PACKET_WIDTH + 2)
) (
  input  logic                    gpio_clock,
  input  logic                    reset,
  input  logic                    scan_en,
  input  logic                    scan_in,
  input  logic                    scan_load,
  input  logic                    data_capture,
  input  logic [DATA_WIDTH-1:0]   sram_data,
  output logic [PACKET_WIDTH-1:0] gpio_packet,
  output logic                    packet_valid,
  output logic                    scan_out,
  output logic [CNT_WIDTH-1:0]    bit_count,
  output logic                    frame_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_full = CNT_WIDTH'(PACKET_WIDTH);
  // One past a full packet marks an overrun and is where the counter parks.
  localparam logic [CNT_WIDTH-1:0] c_cnt_sat  = CNT_WIDTH'(PACKET_WIDTH + 1);

  logic [1:0]              r_state;
  logic [PACKET_WIDTH-1:0] r_shift_reg;
  logic [DATA_WIDTH-1:0]   r_readout_reg;

  always_ff @(posedge gpio_clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift_reg  <= '0;
      gpio_packet  <= '0;
      packet_valid <= 1'b0;
      bit_count    <= '0;
      frame_error  <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scan_en) begin
            r_shift_reg <= {r_shift_reg[PACKET_WIDTH-2:0], scan_in};
            bit_count   <= c_cnt_one;
            r_state     <= S_SHIFT;
          end else if (scan_load) begin
            frame_error <= 1'b1;
          end
        end
        S_SHIFT: begin
          // A shift always wins over a simultaneous load request.
          if (scan_en) begin
            r_shift_reg <= {r_shift_reg[PACKET_WIDTH-2:0], scan_in};
            if (bit_count != c_cnt_sat) begin
              bit_count <= bit_count + c_cnt_one;
            end
          end else if (scan_load) begin
            if (bit_count == c_cnt_full) begin
              r_state <= S_COMMIT;
            end else begin
              frame_error <= 1'b1;
              bit_count   <= '0;
              r_state     <= S_IDLE;
            end
          end
        end
        S_COMMIT: begin
          // Scan inputs are deliberately ignored for this one cycle.
          gpio_packet  <= r_shift_reg;
          packet_valid <= 1'b1;
          bit_count    <= '0;
          frame_error  <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Readout path runs regardless of packet state so it can overlap the next frame.
  always_ff @(posedge gpio_clock or negedge reset) begin
    if (!reset) begin
      r_readout_reg <= '0;
    end else if (data_capture) begin
      r_readout_reg <= sram_data;
    end else if (scan_en) begin
      r_readout_reg <= {r_readout_reg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign scan_out = r_readout_reg[DATA_WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_gpio_scan_deserializer.sv
// ============================================================================
// Module  : tb_gpio_scan_deserializer
// Brief   : Self-checking bench for gpio_scan_deserializer: packet scoreboard,
//           table-driven readout vectors and hand-written framing sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_scan_deserializer;

  localparam int PW = 86;
  localparam int DW = 64;
  localparam int CW = $clog2(PW + 2);

  logic          gpio_clock = 1'b0;
  logic          reset = 1'b0;
  logic          scan_en = 1'b0;
  logic          scan_in = 1'b0;
  logic          scan_load = 1'b0;
  logic          data_capture = 1'b0;
  logic [DW-1:0] sram_data = '0;
  logic [PW-1:0] gpio_packet;
  logic          packet_valid;
  logic          scan_out;
  logic [CW-1:0] bit_count;
  logic          frame_error;

  gpio_scan_deserializer #(.PACKET_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .gpio_clock  (gpio_clock),
    .reset       (reset),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_load   (scan_load),
    .data_capture(data_capture),
    .sram_data   (sram_data),
    .gpio_packet (gpio_packet),
    .packet_valid(packet_valid),
    .scan_out    (scan_out),
    .bit_count   (bit_count),
    .frame_error (frame_error)
  );

  always #5 gpio_clock = ~gpio_clock;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW-1:0] sb[$];

  typedef struct {
    logic          cap;
    logic          en;
    logic [DW-1:0] data;
    logic          exp_out;
  } rvec_t;
  rvec_t rtbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every packet_valid pulse must match the next committed packet in order.
  always @(negedge gpio_clock) begin
    if (packet_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_valid: got packet_valid=1 expected 0 (packet %0h)", gpio_packet);
      end else begin
        check("sb_packet", 128'(gpio_packet), 128'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge gpio_clock);
    #1;
  endtask

  task automatic shift_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      scan_en = 1'b1;
      scan_in = v[i];
      step();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic pulse_load();
    scan_load = 1'b1;
    step();
    scan_load = 1'b0;
  endtask

  logic [PW-1:0]  pkt_nom, pkt_a, pkt_b, pkt_c, pkt_d, pkt_e;
  logic [127:0]   v_over;
  logic [DW-1:0]  rd_word, rd_model;
  logic [DW-1:0]  w;

  initial begin
    // Illustrative field layout: sel(SRAM0), we, wmask, addr, din, pad.
    pkt_nom = {4'd0, 1'b1, 4'hF, 8'd1, 32'd1, 37'd0};
    pkt_a   = {$urandom, $urandom, $urandom};
    pkt_b   = {$urandom, $urandom, $urandom};
    pkt_c   = {$urandom, $urandom, $urandom};
    pkt_d   = {$urandom, $urandom, $urandom};
    pkt_e   = {$urandom, $urandom, $urandom};
    v_over  = {$urandom, $urandom, $urandom, $urandom};
    rd_word = {$urandom, $urandom};

    // Reset held with random activity on every input.
    for (int i = 0; i < 8; i++) begin
      scan_en      = 1'($urandom);
      scan_in      = 1'($urandom);
      scan_load    = 1'($urandom);
      data_capture = 1'($urandom);
      sram_data    = {$urandom, $urandom};
      step();
    end
    check("in_reset_outputs", {bit_count, frame_error, scan_out, packet_valid}, '0);
    scan_en = 0; scan_in = 0; scan_load = 0; data_capture = 0; sram_data = '0;
    reset = 1'b1;
    step();
    check("rst_gpio_packet", 128'(gpio_packet), '0);
    check("rst_packet_valid", 128'(packet_valid), '0);
    check("rst_bit_count", 128'(bit_count), '0);
    check("rst_frame_error", 128'(frame_error), '0);
    check("rst_scan_out", 128'(scan_out), '0);

    // Nominal write packet with exact load latency.
    shift_bits(128'(pkt_nom), PW);
    check("nom_bit_count", 128'(bit_count), 128'(PW));
    sb.push_back(pkt_nom);
    pulse_load();
    check("nom_valid_commit_cycle", 128'(packet_valid), '0);
    step();
    check("nom_valid_pulse", 128'(packet_valid), 128'(1));
    check("nom_packet", 128'(gpio_packet), 128'(pkt_nom));
    check("nom_count_clear", 128'(bit_count), '0);
    step();
    check("nom_valid_drop", 128'(packet_valid), '0);

    // Short frame.
    shift_bits(128'(pkt_a), PW - 1);
    pulse_load();
    check("short_frame_error", 128'(frame_error), 128'(1));
    check("short_count", 128'(bit_count), '0);
    check("short_packet_kept", 128'(gpio_packet), 128'(pkt_nom));

    // Overrun frame: counter parks at PW+1.
    shift_bits(v_over, PW + 4);
    check("over_count_sat", 128'(bit_count), 128'(PW + 1));
    pulse_load();
    check("over_frame_error", 128'(frame_error), 128'(1));
    check("over_packet_kept", 128'(gpio_packet), 128'(pkt_nom));

    // Good frame after errors clears the sticky flag.
    shift_bits(128'(pkt_b), PW);
    sb.push_back(pkt_b);
    pulse_load();
    step();
    check("recover_packet", 128'(gpio_packet), 128'(pkt_b));
    check("recover_error_clear", 128'(frame_error), '0);
    step();

    // Load coinciding with the final shift is ignored; a later lone load commits.
    shift_bits(128'(pkt_c >> 1), PW - 1);
    scan_en = 1'b1; scan_in = pkt_c[0]; scan_load = 1'b1;
    step();
    scan_en = 1'b0; scan_in = 1'b0; scan_load = 1'b0;
    check("simul_count", 128'(bit_count), 128'(PW));
    step();
    check("simul_no_commit", 128'(gpio_packet), 128'(pkt_b));
    sb.push_back(pkt_c);
    pulse_load();
    step();
    check("simul_late_commit", 128'(gpio_packet), 128'(pkt_c));
    step();

    // Lone load while idle flags an error.
    pulse_load();
    check("idle_load_error", 128'(frame_error), 128'(1));

    // Readout vector table.
    rtbl.push_back('{cap: 1'b1, en: 1'b0, data: 64'h1, exp_out: 1'b0});
    for (int k = 1; k <= DW; k++)
      rtbl.push_back('{cap: 1'b0, en: 1'b1, data: '0, exp_out: (k == DW - 1)});
    w = 64'h8000_0000_0000_0000;
    rtbl.push_back('{cap: 1'b1, en: 1'b1, data: w, exp_out: 1'b1});
    rtbl.push_back('{cap: 1'b0, en: 1'b1, data: '0, exp_out: 1'b0});
    w = 64'hC000_0000_0000_0000;
    rtbl.push_back('{cap: 1'b1, en: 1'b1, data: w, exp_out: 1'b1});
    rtbl.push_back('{cap: 1'b0, en: 1'b1, data: '0, exp_out: 1'b1});
    rtbl.push_back('{cap: 1'b0, en: 1'b1, data: '0, exp_out: 1'b0});
    foreach (rtbl[i]) begin
      data_capture = rtbl[i].cap;
      scan_en      = rtbl[i].en;
      sram_data    = rtbl[i].data;
      step();
      check($sformatf("readout_vec%0d", i), 128'(scan_out), 128'(rtbl[i].exp_out));
    end
    data_capture = 1'b0; scan_en = 1'b0; sram_data = '0;
    pulse_load();  // abandon the partial frame the readout shifts created
    check("readout_abort_count", 128'(bit_count), '0);

    // Full duplex: next packet in while the captured word goes out.
    sram_data = rd_word; data_capture = 1'b1;
    step();
    data_capture = 1'b0; sram_data = '0;
    rd_model = rd_word;
    check("fd_first_bit", 128'(scan_out), 128'(rd_model[DW-1]));
    for (int i = PW - 1; i >= 0; i--) begin
      scan_en = 1'b1; scan_in = pkt_d[i];
      step();
      rd_model = rd_model << 1;
      check($sformatf("fd_scan_out_%0d", i), 128'(scan_out), 128'(rd_model[DW-1]));
    end
    scan_en = 1'b0; scan_in = 1'b0;
    sb.push_back(pkt_d);
    pulse_load();
    scan_en = 1'b1; scan_in = 1'b1;  // arrives during COMMIT and must be dropped
    step();
    scan_en = 1'b0; scan_in = 1'b0;
    check("fd_packet", 128'(gpio_packet), 128'(pkt_d));
    check("fd_valid", 128'(packet_valid), 128'(1));
    check("fd_commit_bit_dropped", 128'(bit_count), '0);
    step();

    // Asynchronous reset mid-shift.
    shift_bits(128'(pkt_e), 40);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", 128'(bit_count), '0);
    check("async_rst_packet", 128'(gpio_packet), '0);
    step();
    reset = 1'b1;
    step();

    // Reset during COMMIT: no pulse may follow.
    shift_bits(128'(pkt_e), PW);
    pulse_load();
    reset = 1'b0;
    #1;
    check("commit_rst_valid", 128'(packet_valid), '0);
    check("commit_rst_packet", 128'(gpio_packet), '0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    step();
    check("commit_rst_idle_count", 128'(bit_count), '0);

    check("sb_drained", 128'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
